alu_rtl: RTL and testbench
==========================

# alu_rtl

Registered arithmetic/logic unit that the team's ALU bench drives and monitors. It sits behind the bench's driver and monitor clocking blocks. It accepts operands that may arrive split across cycles under `INP_VALID`, collects them with a 16-cycle timeout, and executes one command per completed operand set. Results and flags are registered, appear one cycle after operand completion, and are frozen while `CE` is low.

## Interface
- OP_WIDTH, 8, operand width W
- CMD_WIDTH, 4, command field width
- TIMEOUT, 16, CE-enabled cycles allowed for the missing operand to arrive
- clk  input  1  single clock, rising edge
- RST  input  1  reset, asynchronous, active-high
- CE  input  1  clock enable; low freezes all state and outputs
- INP_VALID  input  2  01: OPA valid; 10: OPB valid; 11: both valid; 00: idle
- MODE  input  1  1: arithmetic, 0: logical
- CMD  input  CMD_WIDTH  command code
- OPA, OPB  input  W  operands
- CIN  input  1  carry/borrow in
- RES  output  W+1  result; bit W is carry or borrow where defined, otherwise 0
- COUT  output  1  carry out
- OFLOW  output  1  borrow/underflow
- G, L, E  output  1 each  compare flags (OPA>OPB, OPA<OPB, OPA==OPB)
- ERR  output  1  error: invalid command, timeout, or rotate range

## Operation
- Arithmetic commands (MODE=1):
  - 0 ADD, 1 SUB, 2 ADD_CIN, 3 SUB_CIN
  - 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B
  - 8 CMP
- Logical commands (MODE=0):
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR
  - 6 NOT_A, 7 NOT_B
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B
  - 12 ROL_A_B, 13 ROR_A_B
- Invalid commands: CMD>8 with MODE=1, or CMD>13 with MODE=0 -> ERR=1, RES=0, other flags 0.
- Operand need:
  - OPA only: INC_A, DEC_A, NOT_A, SHR1_A, SHL1_A.
  - OPB only: INC_B, DEC_B, NOT_B, SHR1_B, SHL1_B.
  - Both operands: all other commands.
- Arithmetic rules:
  - Operands are unsigned. Internal results are W+1 bits.
  - ADD, ADD_CIN, INC_x: COUT = RES[W].
  - SUB, SUB_CIN, DEC_x: OFLOW = 1 on borrow, and RES holds the W+1-bit two's-complement difference.
  - CMP: RES=0 and exactly one of G/L/E is 1. G/L/E are 0 for every other command.
- Logical results are zero-extended to W+1 bits. COUT and OFLOW are 0.
- Rotate: amount = OPB[log2(W)-1:0]. If any higher OPB bit is set, ERR=1 and RES still carries the rotated value.
- State machine:
  - IDLE -> EXEC when INP_VALID provides every operand the command needs (result registered at that edge).
  - IDLE -> WAIT when the input is partial. MODE, CMD, CIN and the supplied operand are latched; counter=0.
  - WAIT -> EXEC when the missing operand arrives (INP_VALID = complementary code or 11). The latched MODE/CMD/CIN are used; a newly presented copy of the latched operand is ignored.
  - WAIT -> IDLE with ERR=1 when the counter reaches TIMEOUT without completion. RES=0 and the other flags are 0.
  - EXEC is a single registered cycle, then IDLE, or straight into the next operation if new valid input is present.
- INP_VALID=00 in IDLE: no operation; outputs hold.
- Each new result or error replaces all outputs. Every flag not set by the current operation is driven to 0.

## Timing
- Reset (asynchronous, any time, including while in WAIT): state=IDLE, counter=0, latches cleared.
  - RES=0, COUT=0, OFLOW=0, G=L=E=0, ERR=0.
  - The first input sampled after RST deasserts is treated as new.
- Latency: operand completion sampled at edge T -> outputs updated after edge T, stable when sampled at T+1.
- Throughput: one operation per cycle with INP_VALID=11.
- Timeout: partial input at edge T. If nothing completes by edge T+16 (CE-enabled edges), ERR=1 after edge T+16 and reads 1 when sampled at T+17.
  - Completion arriving exactly at edge T+16 wins; no ERR.
- CE=0: the edge is ignored entirely. The counter does not advance and all outputs stay stable.
- Partial input for a different CMD while in WAIT: the latched command is kept; only the missing operand is consumed.

## Test plan
- Reset: assert RST mid-WAIT -> all outputs 0 immediately. After release, INP_VALID=11, MODE=1, CMD=0, OPA=8'hFF, OPB=8'h01 -> RES=9'h100, COUT=1 one cycle later.
- Split operands: INP_VALID=01, OPA=5, MODE=1, CMD=1; 3 cycles later INP_VALID=10, OPB=7 -> RES=9'h1FE, OFLOW=1, ERR=0.
- Timeout: INP_VALID=01, CMD=0, then 16 cycles of 00 -> ERR=1 at T+17, RES=0. Repeat with OPB arriving on cycle 16 -> no ERR, correct sum.
- CE freeze: enter WAIT, hold CE=0 for 30 cycles, then CE=1 and supply OPB within 16 cycles -> correct result, no ERR, outputs stable throughout the freeze.
- Compare and invalid command: CMP with OPA=OPB=8'h3C -> E=1, G=L=0. MODE=1, CMD=9 -> ERR=1, RES=0.
- Rotate: MODE=0, CMD=12, OPA=8'h81, OPB=8'h01 -> RES=9'h003, ERR=0. Same with OPB=8'h11 -> RES=9'h003, ERR=1.

Source files
------------

// File: rtl/alu_rtl.sv
// Registered ALU with split-operand collection, a bounded wait for the missing
// operand, and a clock enable that freezes every register.
module alu_rtl #(
   parameter int OP_WIDTH  = 8,
   parameter int CMD_WIDTH = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 RST,
   input  logic                 CE,
   input  logic [1:0]           INP_VALID,
   input  logic                 MODE,
   input  logic [CMD_WIDTH-1:0] CMD,
   input  logic [OP_WIDTH-1:0]  OPA,
   input  logic [OP_WIDTH-1:0]  OPB,
   input  logic                 CIN,
   output logic [OP_WIDTH:0]    RES,
   output logic                 COUT,
   output logic                 OFLOW,
   output logic                 G,
   output logic                 L,
   output logic                 E,
   output logic                 ERR,
   output logic [1:0]           state_dbg
);

   localparam int SH_W  = $clog2(OP_WIDTH);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   // Handshake: INP_VALID bit 0 qualifies OPA, bit 1 qualifies OPB; each
   // CE-enabled edge consumes whatever is flagged, there is no back-pressure.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_EXEC = 2'd2
   } state_t;

   state_t                state, state_n;
   logic [CNT_W-1:0]      cnt, cnt_n;
   logic                  mode_l, cin_l;
   logic [CMD_WIDTH-1:0]  cmd_l;
   logic [OP_WIDTH-1:0]   opa_l, opb_l;
   logic [1:0]            have_l;

   logic                  sel_mode, sel_cin;
   logic [CMD_WIDTH-1:0]  sel_cmd;
   logic [OP_WIDTH-1:0]   sel_a, sel_b;
   logic [1:0]            avail, need;
   logic                  complete;
   logic                  do_exec, do_tout, do_latch;

   logic [OP_WIDTH:0]     c_res;
   logic                  c_cout, c_oflow, c_g, c_l, c_e, c_err;
   logic [OP_WIDTH:0]     ea, eb, ec, one;
   logic [2*OP_WIDTH-1:0] dbl, rol_full, ror_full;
   logic                  rot_err;

   // Bit 0: command needs OPA, bit 1: needs OPB. Invalid commands need nothing
   // so they are reported as soon as any input is flagged.
   function automatic logic [1:0] need_ops(input logic mode, input logic [CMD_WIDTH-1:0] cmd);
      logic [1:0] n;
      n = 2'b00;
      if (mode) begin
         case (int'(cmd))
            0, 1, 2, 3, 8: n = 2'b11;
            4, 5:          n = 2'b01;
            6, 7:          n = 2'b10;
            default:       n = 2'b00;
         endcase
      end else begin
         case (int'(cmd))
            0, 1, 2, 3, 4, 5, 12, 13: n = 2'b11;
            6, 8, 9:                  n = 2'b01;
            7, 10, 11:                n = 2'b10;
            default:                  n = 2'b00;
         endcase
      end
      return n;
   endfunction

   always_comb begin
      if (state == S_WAIT) begin
         sel_mode = mode_l;
         sel_cmd  = cmd_l;
         sel_cin  = cin_l;
         sel_a    = have_l[0] ? opa_l : OPA;
         sel_b    = have_l[1] ? opb_l : OPB;
         avail    = have_l | INP_VALID;
      end else begin
         sel_mode = MODE;
         sel_cmd  = CMD;
         sel_cin  = CIN;
         sel_a    = OPA;
         sel_b    = OPB;
         avail    = INP_VALID;
      end
   end

   assign need     = need_ops(sel_mode, sel_cmd);
   assign complete = (INP_VALID != 2'b00) && ((avail & need) == need);

   assign ea       = {1'b0, sel_a};
   assign eb       = {1'b0, sel_b};
   assign ec       = {{OP_WIDTH{1'b0}}, sel_cin};
   assign one      = {{OP_WIDTH{1'b0}}, 1'b1};
   assign dbl      = {sel_a, sel_a};
   assign rol_full = dbl << sel_b[SH_W-1:0];
   assign ror_full = dbl >> sel_b[SH_W-1:0];
   assign rot_err  = (sel_b >> SH_W) != '0;

   always_comb begin
      c_res   = '0;
      c_cout  = 1'b0;
      c_oflow = 1'b0;
      c_g     = 1'b0;
      c_l     = 1'b0;
      c_e     = 1'b0;
      c_err   = 1'b0;
      if (sel_mode) begin
         case (int'(sel_cmd))
            0: begin c_res = ea + eb;      c_cout  = c_res[OP_WIDTH]; end
            1: begin c_res = ea - eb;      c_oflow = c_res[OP_WIDTH]; end
            2: begin c_res = ea + eb + ec; c_cout  = c_res[OP_WIDTH]; end
            3: begin c_res = ea - eb - ec; c_oflow = c_res[OP_WIDTH]; end
            4: begin c_res = ea + one;     c_cout  = c_res[OP_WIDTH]; end
            5: begin c_res = ea - one;     c_oflow = c_res[OP_WIDTH]; end
            6: begin c_res = eb + one;     c_cout  = c_res[OP_WIDTH]; end
            7: begin c_res = eb - one;     c_oflow = c_res[OP_WIDTH]; end
            8: begin
               c_g = sel_a > sel_b;
               c_l = sel_a < sel_b;
               c_e = sel_a == sel_b;
            end
            default: c_err = 1'b1;
         endcase
      end else begin
         case (int'(sel_cmd))
            0:  c_res = {1'b0, sel_a & sel_b};
            1:  c_res = {1'b0, ~(sel_a & sel_b)};
            2:  c_res = {1'b0, sel_a | sel_b};
            3:  c_res = {1'b0, ~(sel_a | sel_b)};
            4:  c_res = {1'b0, sel_a ^ sel_b};
            5:  c_res = {1'b0, ~(sel_a ^ sel_b)};
            6:  c_res = {1'b0, ~sel_a};
            7:  c_res = {1'b0, ~sel_b};
            8:  c_res = {1'b0, sel_a >> 1};
            9:  c_res = {1'b0, sel_a << 1};
            10: c_res = {1'b0, sel_b >> 1};
            11: c_res = {1'b0, sel_b << 1};
            12: begin c_res = {1'b0, rol_full[2*OP_WIDTH-1:OP_WIDTH]}; c_err = rot_err; end
            13: begin c_res = {1'b0, ror_full[OP_WIDTH-1:0]};          c_err = rot_err; end
            default: c_err = 1'b1;
         endcase
      end
   end

   // EXEC behaves like IDLE for new input, which gives back-to-back throughput.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      do_exec  = 1'b0;
      do_tout  = 1'b0;
      do_latch = 1'b0;
      case (state)
         S_WAIT: begin
            if (complete) begin
               do_exec = 1'b1;
               state_n = S_EXEC;
               cnt_n   = '0;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               do_tout = 1'b1;
               state_n = S_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            if (complete) begin
               do_exec = 1'b1;
               state_n = S_EXEC;
            end else if (INP_VALID != 2'b00) begin
               do_latch = 1'b1;
               state_n  = S_WAIT;
               cnt_n    = '0;
            end else begin
               state_n = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST)     state <= S_IDLE;
      else if (CE) state <= state_n;
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         cnt    <= '0;
         mode_l <= 1'b0;
         cmd_l  <= '0;
         cin_l  <= 1'b0;
         opa_l  <= '0;
         opb_l  <= '0;
         have_l <= 2'b00;
         RES    <= '0;
         COUT   <= 1'b0;
         OFLOW  <= 1'b0;
         G      <= 1'b0;
         L      <= 1'b0;
         E      <= 1'b0;
         ERR    <= 1'b0;
      end else if (CE) begin
         cnt <= cnt_n;
         if (do_latch) begin
            mode_l <= MODE;
            cmd_l  <= CMD;
            cin_l  <= CIN;
            opa_l  <= OPA;
            opb_l  <= OPB;
            have_l <= INP_VALID;
         end
         if (do_exec) begin
            RES   <= c_res;
            COUT  <= c_cout;
            OFLOW <= c_oflow;
            G     <= c_g;
            L     <= c_l;
            E     <= c_e;
            ERR   <= c_err;
         end else if (do_tout) begin
            RES   <= '0;
            COUT  <= 1'b0;
            OFLOW <= 1'b0;
            G     <= 1'b0;
            L     <= 1'b0;
            E     <= 1'b0;
            ERR   <= 1'b1;
         end
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_alu_rtl.sv
// Bench for alu_rtl: directed split/timeout/freeze/rotate cases plus random
// back-to-back operations, all scored against a behavioural model.
module tb_alu_rtl;

   logic       clk;
   logic       RST;
   logic       CE;
   logic [1:0] INP_VALID;
   logic       MODE;
   logic [3:0] CMD;
   logic [7:0] OPA, OPB;
   logic       CIN;
   logic [8:0] RES;
   logic       COUT, OFLOW, G, L, E, ERR;
   logic [1:0] state_dbg;

   logic [14:0] exp_q[$];
   logic [14:0] last_exp;
   string       cur_tag;
   int          n_checks = 0;
   int          n_errors = 0;

   alu_rtl dut (
      .clk(clk), .RST(RST), .CE(CE), .INP_VALID(INP_VALID), .MODE(MODE),
      .CMD(CMD), .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES), .COUT(COUT),
      .OFLOW(OFLOW), .G(G), .L(L), .E(E), .ERR(ERR), .state_dbg(state_dbg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [14:0] mk(input logic [8:0] r, input logic co, input logic of,
                                      input logic g, input logic l, input logic e, input logic er);
      return {r, co, of, g, l, e, er};
   endfunction

   function automatic logic [14:0] outs();
      return {RES, COUT, OFLOW, G, L, E, ERR};
   endfunction

   // Integer-arithmetic reference for one completed operation.
   function automatic logic [14:0] model(input logic mode, input logic [3:0] cmd, input logic cin,
                                         input logic [7:0] a, input logic [7:0] b);
      int r, ai, bi, ci, k;
      logic co, of, g, l, e, er;
      ai = a; bi = b; ci = cin;
      r = 0; co = 0; of = 0; g = 0; l = 0; e = 0; er = 0;
      k = bi % 8;
      if (mode) begin
         case (cmd)
            0: begin r = ai + bi;      co = r > 255; end
            1: begin r = ai - bi;      of = r < 0;   end
            2: begin r = ai + bi + ci; co = r > 255; end
            3: begin r = ai - bi - ci; of = r < 0;   end
            4: begin r = ai + 1;       co = r > 255; end
            5: begin r = ai - 1;       of = r < 0;   end
            6: begin r = bi + 1;       co = r > 255; end
            7: begin r = bi - 1;       of = r < 0;   end
            8: begin g = ai > bi; l = ai < bi; e = ai == bi; end
            default: er = 1;
         endcase
      end else begin
         case (cmd)
            0:  r = ai & bi;
            1:  r = 255 - (ai & bi);
            2:  r = ai | bi;
            3:  r = 255 - (ai | bi);
            4:  r = ai ^ bi;
            5:  r = 255 - (ai ^ bi);
            6:  r = 255 - ai;
            7:  r = 255 - bi;
            8:  r = ai / 2;
            9:  r = (ai * 2) % 256;
            10: r = bi / 2;
            11: r = (bi * 2) % 256;
            12: begin r = ((ai << k) | (ai >> (8 - k))) & 255; er = bi > 7; end
            13: begin r = ((ai >> k) | (ai << (8 - k))) & 255; er = bi > 7; end
            default: er = 1;
         endcase
      end
      return {r[8:0], co, of, g, l, e, er};
   endfunction

   task automatic drive(input logic [1:0] v, input logic m, input logic [3:0] c,
                        input logic [7:0] a, input logic [7:0] b, input logic ci);
      INP_VALID = v;
      MODE      = m;
      CMD       = c;
      OPA       = a;
      OPB       = b;
      CIN       = ci;
   endtask

   task automatic idle();
      INP_VALID = 2'b00;
   endtask

   // One clock; the result expected from this edge is popped and compared.
   task automatic tick();
      logic [14:0] e;
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         last_exp = e;
         check(cur_tag, 32'(outs()), 32'(e));
      end
   endtask

   initial begin
      RST = 1'b1;
      CE  = 1'b1;
      drive(2'b00, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
      last_exp = '0;
      #1;
      check("reset_outs", 32'(outs()), 32'(0));
      check("reset_state", 32'(state_dbg), 32'(0));
      @(negedge clk);
      RST = 1'b0;

      cur_tag = "add_ff_01";
      drive(2'b11, 1'b1, 4'd0, 8'hFF, 8'h01, 1'b0);
      exp_q.push_back(mk(9'h100, 1, 0, 0, 0, 0, 0));
      tick();
      check("exec_state", 32'(state_dbg), 32'(2));

      // Async reset while waiting for OPB.
      drive(2'b01, 1'b1, 4'd0, 8'h33, 8'h00, 1'b0);
      tick();
      check("wait_state", 32'(state_dbg), 32'(1));
      RST = 1'b1;
      #1;
      check("rst_mid_wait_outs", 32'(outs()), 32'(0));
      check("rst_mid_wait_state", 32'(state_dbg), 32'(0));
      @(negedge clk);
      RST = 1'b0;
      cur_tag = "add_after_rst";
      drive(2'b11, 1'b1, 4'd0, 8'hFF, 8'h01, 1'b0);
      exp_q.push_back(mk(9'h100, 1, 0, 0, 0, 0, 0));
      tick();

      // Split SUB: OPA now, OPB three cycles later.
      drive(2'b01, 1'b1, 4'd1, 8'd5, 8'd0, 1'b0);
      tick();
      idle();
      tick();
      tick();
      check("split_hold", 32'(outs()), 32'(last_exp));
      cur_tag = "split_sub";
      drive(2'b10, 1'b1, 4'd0, 8'd0, 8'd7, 1'b0);
      exp_q.push_back(mk(9'h1FE, 0, 1, 0, 0, 0, 0));
      tick();

      // Timeout: 16 enabled edges without OPB.
      drive(2'b01, 1'b1, 4'd0, 8'd9, 8'd0, 1'b0);
      tick();
      idle();
      for (int i = 0; i < 15; i++) tick();
      check("tout_not_yet", 32'(outs()), 32'(last_exp));
      check("tout_still_wait", 32'(state_dbg), 32'(1));
      cur_tag = "timeout_err";
      exp_q.push_back(mk(9'h0, 0, 0, 0, 0, 0, 1));
      tick();

      // OPB arriving on the 16th edge completes.
      drive(2'b01, 1'b1, 4'd0, 8'd9, 8'd0, 1'b0);
      tick();
      idle();
      for (int i = 0; i < 15; i++) tick();
      cur_tag = "tout_edge_win";
      drive(2'b10, 1'b1, 4'd0, 8'd0, 8'd4, 1'b0);
      exp_q.push_back(mk(9'd13, 0, 0, 0, 0, 0, 0));
      tick();

      // In WAIT a different command and a fresh OPA are ignored.
      drive(2'b01, 1'b1, 4'd0, 8'd20, 8'd0, 1'b0);
      tick();
      cur_tag = "wait_keeps_cmd";
      drive(2'b11, 1'b0, 4'd4, 8'd99, 8'd3, 1'b1);
      exp_q.push_back(mk(9'd23, 0, 0, 0, 0, 0, 0));
      tick();

      // CE freeze in WAIT, even with OPB offered.
      drive(2'b01, 1'b1, 4'd0, 8'h80, 8'h00, 1'b0);
      tick();
      CE = 1'b0;
      drive(2'b10, 1'b1, 4'd0, 8'h00, 8'h01, 1'b0);
      for (int i = 0; i < 30; i++) begin
         tick();
         check("freeze_outs", 32'(outs()), 32'(last_exp));
         check("freeze_state", 32'(state_dbg), 32'(1));
      end
      CE = 1'b1;
      idle();
      for (int i = 0; i < 10; i++) tick();
      cur_tag = "after_freeze";
      drive(2'b10, 1'b1, 4'd0, 8'h00, 8'h90, 1'b0);
      exp_q.push_back(mk(9'h110, 1, 0, 0, 0, 0, 0));
      tick();

      cur_tag = "cmp_eq";
      drive(2'b11, 1'b1, 4'd8, 8'h3C, 8'h3C, 1'b0);
      exp_q.push_back(mk(9'h0, 0, 0, 0, 0, 1, 0));
      tick();
      cur_tag = "cmp_gt";
      drive(2'b11, 1'b1, 4'd8, 8'h50, 8'h3C, 1'b0);
      exp_q.push_back(mk(9'h0, 0, 0, 1, 0, 0, 0));
      tick();
      cur_tag = "invalid_arith";
      drive(2'b11, 1'b1, 4'd9, 8'h12, 8'h34, 1'b0);
      exp_q.push_back(mk(9'h0, 0, 0, 0, 0, 0, 1));
      tick();
      cur_tag = "invalid_logic";
      drive(2'b01, 1'b0, 4'd14, 8'h12, 8'h34, 1'b0);
      exp_q.push_back(mk(9'h0, 0, 0, 0, 0, 0, 1));
      tick();
      cur_tag = "rol_ok";
      drive(2'b11, 1'b0, 4'd12, 8'h81, 8'h01, 1'b0);
      exp_q.push_back(mk(9'h003, 0, 0, 0, 0, 0, 0));
      tick();
      cur_tag = "rol_range";
      drive(2'b11, 1'b0, 4'd12, 8'h81, 8'h11, 1'b0);
      exp_q.push_back(mk(9'h003, 0, 0, 0, 0, 0, 1));
      tick();
      cur_tag = "ror_ok";
      drive(2'b11, 1'b0, 4'd13, 8'h81, 8'h02, 1'b0);
      exp_q.push_back(mk(9'h060, 0, 0, 0, 0, 0, 0));
      tick();
      idle();
      tick();
      check("idle_hold", 32'(outs()), 32'(last_exp));

      // Back-to-back random operations with both operands valid.
      cur_tag = "random_op";
      for (int i = 0; i < 60; i++) begin
         logic       m, ci;
         logic [3:0] c;
         logic [7:0] a, b;
         m  = 1'($urandom_range(0, 1));
         c  = 4'($urandom_range(0, 15));
         a  = 8'($urandom_range(0, 255));
         b  = 8'($urandom_range(0, 15)) | ((i % 3 == 0) ? 8'($urandom_range(0, 255)) : 8'h00);
         ci = 1'($urandom_range(0, 1));
         drive(2'b11, m, c, a, b, ci);
         exp_q.push_back(model(m, c, ci, a, b));
         tick();
      end
      idle();
      tick();
      check("queue_empty", 32'(exp_q.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
